scp_fetch_stage: RTL and testbench

- Instruction-fetch stage for the single-cycle add/noop processor. It sits directly upstream of the decode/execute datapath.
- Owns the program counter and drives a synchronous instruction memory with 1-cycle read latency.
- Delivers {pc, instruction} words through a 2-entry skid buffer using a valid/ready handshake.
- Accepts a redirect (jump/branch target) that flushes in-flight and buffered work.

---
 rtl/scp_pkg.sv | 17 +
 rtl/scp_fetch_stage_if.sv | 46 ++++
 rtl/scp_skid_buf.sv | 73 +++++++
 rtl/scp_fetch_stage.sv | 119 +++++++++++
 tb/tb_scp_fetch_stage.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scp_pkg.sv
// Shared types and constants for the single-cycle add/noop processor.
// Holds the fetch FSM state type, default bus widths and the NOOP encoding.
package scp_pkg;

    localparam int SCP_ADDR_W = 8;
    localparam int SCP_DATA_W = 32;

    // All-zero word decodes as "add r0, r0, r0", which the datapath treats as a noop
    localparam logic [SCP_DATA_W-1:0] SCP_NOOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/scp_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory read port, instruction handshake and redirect.
// The master side is the fetch stage; the slave side is memory plus downstream.
interface scp_fetch_stage_if
    import scp_pkg::*;
#(
    parameter int ADDR_W = SCP_ADDR_W,
    parameter int DATA_W = SCP_DATA_W
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;

    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/scp_skid_buf.sv
// Two-entry valid/ready buffer carrying {pc, instruction}, head-first ordering.
// A flush empties it in one cycle; a same-cycle pop is still honoured downstream.
module scp_skid_buf #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [ADDR_W-1:0] tail_pc;
    logic [DATA_W-1:0] tail_data;
    logic              do_push;
    logic              do_pop;

    assign valid   = (count != 2'd0);
    assign do_pop  = pop && valid;
    assign do_push = push && ((count != 2'd2) || do_pop);

    // The head register always drives the outputs, so data only moves on a pop or into an empty head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= 2'd0;
            head_pc   <= '0;
            head_data <= '0;
            tail_pc   <= '0;
            tail_data <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc   <= push_pc;
                        head_data <= push_data;
                    end else begin
                        tail_pc   <= push_pc;
                        tail_data <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pc   <= tail_pc;
                    head_data <= tail_data;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_pc   <= push_pc;
                        head_data <= push_data;
                    end else begin
                        head_pc   <= tail_pc;
                        head_data <= tail_data;
                        tail_pc   <= push_pc;
                        tail_data <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/scp_fetch_stage.sv
// Instruction-fetch stage: PC, 1-cycle-latency memory requests, redirect/flush FSM.
// Optional SCP_FETCH_PERF_EN adds saturating accept and stall counters.
module scp_fetch_stage
    import scp_pkg::*;
#(
    parameter int                ADDR_W   = SCP_ADDR_W,
    parameter int                DATA_W   = SCP_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    scp_fetch_stage_if.master bus
`ifdef SCP_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic              issue;
    logic              accept;
    logic              push;
    logic [1:0]        count;
    logic [2:0]        occupancy;

    assign accept = bus.inst_valid && bus.inst_ready;

    // Counting the same-cycle pop as a freed slot is what lets ready=1 sustain one fetch per cycle
    assign occupancy = {1'b0, count} - {2'b00, accept} + {2'b00, inflight};

    // A response arriving in a redirect cycle belongs to the old stream and is dropped
    assign push = inflight && !bus.redirect_valid;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                state_next = bus.redirect_valid ? FLUSH : RUN;
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    state_next = FLUSH;
                end else begin
                    issue = (count != 2'd2) && (occupancy < 3'd2);
                end
            end
            FLUSH: begin
                state_next = bus.redirect_valid ? FLUSH : RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if (issue) begin
                req_pc <= pc;
            end
            if (bus.redirect_valid) begin
                pc <= bus.redirect_pc;
            end else if (issue) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

    scp_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_pc   (req_pc),
        .push_data (bus.imem_rdata),
        .pop       (bus.inst_ready),
        .valid     (bus.inst_valid),
        .head_pc   (bus.inst_pc),
        .head_data (bus.inst_data),
        .count     (count)
    );

`ifdef SCP_FETCH_PERF_EN
    // Counters survive redirects; only reset clears them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (accept && (perf_fetched != {32{1'b1}})) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (bus.inst_valid && !bus.inst_ready && (perf_stall != {32{1'b1}})) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scp_fetch_stage.sv
// Self-checking bench for scp_fetch_stage: in-order delivery model, redirect, wrap and reset checks.
// A second instance with RESET_PC=0xFE covers PC wrap-around.
module tb_scp_fetch_stage;
    import scp_pkg::*;

    localparam int AW = SCP_ADDR_W;
    localparam int DW = SCP_DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [AW-1:0] exp_pc;

    scp_fetch_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    scp_fetch_stage_if #(.ADDR_W(AW), .DATA_W(DW)) wbus ();

`ifdef SCP_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, wperf_fetched, wperf_stall;
`endif

    scp_fetch_stage #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SCP_FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    scp_fetch_stage #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(8'hFE)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
`ifdef SCP_FETCH_PERF_EN
        ,
        .perf_fetched (wperf_fetched),
        .perf_stall   (wperf_stall)
`endif
    );

    // Memory content rule: word[i] = i + 100
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(a) + 32'd100;
    endfunction

    always @(posedge clk) begin
        bus.imem_rdata  <= bus.imem_req ? mem_word(bus.imem_addr) : SCP_NOOP;
        wbus.imem_rdata <= wbus.imem_req ? mem_word(wbus.imem_addr) : SCP_NOOP;
    end

    task automatic drive_cycle(input logic ready, input logic redir, input logic [AW-1:0] tgt);
        @(posedge clk);
        #1;
        bus.inst_ready     = ready;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        #1;
    endtask

    task automatic apply_reset();
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_pc = '0;
    endtask

    task automatic test_reset();
        bus.inst_ready = 1'b1;
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.inst_valid); end
        checks++;
        if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", bus.imem_req); end
        checks++;
        if (bus.inst_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", bus.inst_data); end
        checks++;
        if (bus.inst_pc !== '0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", bus.inst_pc); end
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            drive_cycle(1'b1, 1'b0, '0);
            checks++;
            if (k < 3) begin
                if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL early_valid: cycle %0d got %b expected 0", k, bus.inst_valid); end
            end else begin
                if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 8'h00 || bus.inst_data !== 32'd100)
                    begin errors++; $display("[TB] FAIL first_valid: got v=%b pc=%h d=%0d expected v=1 pc=00 d=100", bus.inst_valid, bus.inst_pc, bus.inst_data); end
            end
        end
        exp_pc = 8'h01;
    endtask

    task automatic test_steady();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, '0);
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc))
                begin errors++; $display("[TB] FAIL steady: got v=%b pc=%h d=%0d expected v=1 pc=%h d=%0d", bus.inst_valid, bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc)); end
            exp_pc = exp_pc + 1'b1;
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] hold_pc;
        logic [DW-1:0] hold_data;
        int got;
        drive_cycle(1'b0, 1'b0, '0);
        hold_pc   = bus.inst_pc;
        hold_data = bus.inst_data;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc)
            begin errors++; $display("[TB] FAIL bp_head: got v=%b pc=%h expected v=1 pc=%h", bus.inst_valid, bus.inst_pc, exp_pc); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, '0);
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== hold_pc || bus.inst_data !== hold_data)
                begin errors++; $display("[TB] FAIL bp_stable: got v=%b pc=%h d=%0d expected v=1 pc=%h d=%0d", bus.inst_valid, bus.inst_pc, bus.inst_data, hold_pc, hold_data); end
        end
        checks++;
        if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_req: got %b expected 0", bus.imem_req); end
        checks++;
        if (dut.u_buf.count !== 2'd2) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 2", dut.u_buf.count); end
        got = 0;
        for (int c = 0; c < 20 && got < 6; c++) begin
            drive_cycle(1'b1, 1'b0, '0);
            if (bus.inst_valid === 1'b1) begin
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc))
                    begin errors++; $display("[TB] FAIL bp_drain: got pc=%h d=%0d expected pc=%h d=%0d", bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 1'b1;
                got++;
            end
        end
        checks++;
        if (got != 6) begin errors++; $display("[TB] FAIL bp_drain_timeout: got %0d entries expected 6", got); end
    endtask

    task automatic test_redirect();
        logic [AW-1:0] tgt_list [2];
        tgt_list[0] = 8'h40;
        tgt_list[1] = 8'h90;
        drive_cycle(1'b1, 1'b1, tgt_list[0]);
        if (bus.inst_valid === 1'b1) begin
            checks++;
            if (bus.inst_pc !== exp_pc)
                begin errors++; $display("[TB] FAIL redir_accept: got pc=%h expected %h", bus.inst_pc, exp_pc); end
        end
        exp_pc = tgt_list[0];
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                // Second redirect lands while the stage is still flushing
                drive_cycle(1'b1, 1'b1, 8'h80);
                drive_cycle(1'b1, 1'b1, tgt_list[1]);
                exp_pc = tgt_list[1];
            end
            for (int k = 1; k <= 3; k++) begin
                drive_cycle(1'b1, 1'b0, '0);
                checks++;
                if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_bubble: pass %0d cycle %0d got %b expected 0", pass, k, bus.inst_valid); end
            end
            for (int i = 0; i < 3; i++) begin
                drive_cycle(1'b1, 1'b0, '0);
                checks++;
                if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc))
                    begin errors++; $display("[TB] FAIL redir_target: got v=%b pc=%h d=%0d expected v=1 pc=%h d=%0d", bus.inst_valid, bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 1'b1;
            end
        end
    endtask

    task automatic test_random();
        logic          ready, redir, prev_hold;
        logic [AW-1:0] tgt, hold_pc;
        logic [DW-1:0] hold_data;
        int delivered;
        prev_hold = 1'b0;
        hold_pc   = '0;
        hold_data = '0;
        delivered = 0;
        for (int c = 0; c < 400; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 19) == 0);
            tgt   = AW'($urandom);
            drive_cycle(ready, redir, tgt);
            if (prev_hold) begin
                checks++;
                if (bus.inst_valid !== 1'b1 || bus.inst_pc !== hold_pc || bus.inst_data !== hold_data)
                    begin errors++; $display("[TB] FAIL rnd_stable: cycle %0d got v=%b pc=%h expected v=1 pc=%h", c, bus.inst_valid, bus.inst_pc, hold_pc); end
            end
            if (bus.inst_valid === 1'b1 && ready) begin
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc))
                    begin errors++; $display("[TB] FAIL rnd_order: cycle %0d got pc=%h d=%0d expected pc=%h d=%0d", c, bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 1'b1;
                delivered++;
            end
            if (redir) exp_pc = tgt;
            prev_hold = (bus.inst_valid === 1'b1) && !ready && !redir;
            hold_pc   = bus.inst_pc;
            hold_data = bus.inst_data;
        end
        checks++;
        if (delivered < 100) begin errors++; $display("[TB] FAIL rnd_progress: got %0d deliveries expected at least 100", delivered); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, '0);
        checks++;
        if (bus.inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL ar_full: got v=%b expected 1", bus.inst_valid); end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0)
            begin errors++; $display("[TB] FAIL ar_immediate: got v=%b req=%b expected 0 0", bus.inst_valid, bus.imem_req); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_pc = '0;
        for (int k = 1; k <= 5; k++) begin
            drive_cycle(1'b1, 1'b0, '0);
            checks++;
            if (k < 3) begin
                if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_bubble: cycle %0d got %b expected 0", k, bus.inst_valid); end
            end else begin
                if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc))
                    begin errors++; $display("[TB] FAIL ar_restart: got v=%b pc=%h expected v=1 pc=%h", bus.inst_valid, bus.inst_pc, exp_pc); end
                exp_pc = exp_pc + 1'b1;
            end
        end
    endtask

    task automatic test_pc_wrap();
        logic [AW-1:0] w;
        apply_reset();
        w = 8'hFE;
        for (int k = 1; k <= 6; k++) begin
            drive_cycle(1'b1, 1'b0, '0);
            if (k >= 3) begin
                checks++;
                if (wbus.inst_valid !== 1'b1 || wbus.inst_pc !== w || wbus.inst_data !== mem_word(w))
                    begin errors++; $display("[TB] FAIL wrap_seq: got v=%b pc=%h d=%0d expected v=1 pc=%h d=%0d", wbus.inst_valid, wbus.inst_pc, wbus.inst_data, w, mem_word(w)); end
                w = w + 1'b1;
            end
        end
    endtask

`ifdef SCP_FETCH_PERF_EN
    task automatic test_perf();
        int fe, st;
        logic ready;
        apply_reset();
        fe = 0;
        st = 0;
        for (int c = 0; c < 100 && fe < 10; c++) begin
            ready = !(fe == 5 && st < 4);
            drive_cycle(ready, 1'b0, '0);
            if (bus.inst_valid === 1'b1 && ready) fe++;
            if (bus.inst_valid === 1'b1 && !ready) st++;
        end
        checks++;
        if (fe != 10) begin errors++; $display("[TB] FAIL perf_timeout: got %0d accepts expected 10", fe); end
        drive_cycle(1'b1, 1'b1, 8'h10);
        checks++;
        if (perf_fetched !== 32'(fe) || perf_stall !== 32'(st))
            begin errors++; $display("[TB] FAIL perf_counts: got fetched=%0d stall=%0d expected %0d %0d", perf_fetched, perf_stall, fe, st); end
        if (bus.inst_valid === 1'b1) fe++;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 1'b0, '0);
            if (bus.inst_valid === 1'b1) fe++;
        end
        drive_cycle(1'b1, 1'b0, '0);
        checks++;
        if (perf_fetched !== 32'(fe) || perf_stall !== 32'(st))
            begin errors++; $display("[TB] FAIL perf_after_redirect: got fetched=%0d stall=%0d expected %0d %0d", perf_fetched, perf_stall, fe, st); end
    endtask
`endif

    initial begin
        bus.inst_ready      = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        wbus.inst_ready     = 1'b1;
        wbus.redirect_valid = 1'b0;
        wbus.redirect_pc    = '0;
        exp_pc = '0;
        test_reset();
        test_steady();
        test_backpressure();
        test_redirect();
        test_random();
        test_async_reset();
        test_pc_wrap();
`ifdef SCP_FETCH_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
